cpu_controller: RTL and testbench

- Instruction sequencer for the 8-bit accumulator CPU.
- Sits directly upstream of the alu: drives the memory/IR/PC/accumulator strobes; the alu receives the IR opcode.
- Consumes the alu's is_zero flag for SKZ.
- Runs a fixed 8-phase cycle per instruction, with a halt/resume mechanism.

---
 rtl/cpu_controller.sv | 143 ++++++++++++++
 tb/tb_cpu_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the 8-bit accumulator CPU, with halt/resume.
// Optional single-step stall in phase 0 is enabled by defining CTRL_SINGLE_STEP_EN.
module cpu_controller #(
  parameter int OPW               = 3,
  parameter int HALT_RESUME_PHASE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           is_zero,
  input  logic           run,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic           step_mode,
  input  logic           step,
`endif
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           halt,
  output logic           ld_pc,
  output logic           data_e,
  output logic           ld_ac,
  output logic           wr,
  output logic [2:0]     phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  localparam phase_t RESUME_PHASE = phase_t'(3'(HALT_RESUME_PHASE));

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   stall;
  logic   is_hlt, is_skz, is_sto, is_jmp, alu_op;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign alu_op = (opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA});

`ifdef CTRL_SINGLE_STEP_EN
  // Phase 0 is only ever entered by wrap, reset or resume, so holding there covers all three.
  assign stall = step_mode && !step && (phase_q == INST_ADDR);
`else
  assign stall = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: every output is given a default first so no path through the case infers a latch.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    sel      = 1'b0;
    rd       = 1'b0;
    ld_ir    = 1'b0;
    inc_pc   = 1'b0;
    halt     = 1'b0;
    ld_pc    = 1'b0;
    data_e   = 1'b0;
    ld_ac    = 1'b0;
    wr       = 1'b0;

    if (halted_q) begin
      if (run) begin
        halted_d = 1'b0;
        phase_d  = RESUME_PHASE;
      end
    end else if (phase_q == OP_ADDR && is_hlt) begin
      halted_d = 1'b1;
    end else if (!stall) begin
      phase_d = phase_t'(phase_q + 3'd1);
    end

    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        OP_FETCH:   rd = alu_op;
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && is_zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = is_jmp;
          data_e = is_sto;
          wr     = is_sto;
        end
      endcase
    end
  end

  // phase_q already sits at OP_ADDR while halted, so it doubles as the phase output.
  assign phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: per-instruction phase tables, hand-written
// reset/halt/step sequences, then random stimulus against a rule-based reference model.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst, is_zero, run;
  logic [2:0] opcode;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step_mode, step;
`endif

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .is_zero   (is_zero),
    .run       (run),
`ifdef CTRL_SINGLE_STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .halt      (halt),
    .ld_pc     (ld_pc),
    .data_e    (data_e),
    .ld_ac     (ld_ac),
    .wr        (wr),
    .phase     (phase)
  );

  // {phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
  logic [11:0] dut_v;
  assign dut_v = {phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
               name, act[11:9], act[8:0], exp[11:9], exp[8:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each mask bit i gives the strobe value in phase i.
  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [7:0] m_sel, m_rd, m_ld_ir, m_inc_pc, m_halt, m_ld_pc, m_data_e, m_ld_ac, m_wr;
  } row_t;

  row_t rows[8];

  // Reference model: decode straight from the instruction-level rules.
  function automatic logic [11:0] model_out(input int ph, input bit h, input logic [2:0] op,
                                            input bit z);
    bit alu;
    logic [2:0] p3;
    alu = (op inside {3'd2, 3'd3, 3'd4, 3'd5});
    p3  = ph[2:0];
    if (h) return {3'd4, 9'b0000_1_0000};
    return {p3,
            1'(ph < 4),
            1'((ph >= 1 && ph <= 3) || (ph >= 5 && alu)),
            1'(ph == 2 || ph == 3),
            1'(ph == 4 || (ph == 6 && op == 3'd1 && z)),
            1'(ph == 4 && op == 3'd0),
            1'(ph >= 6 && op == 3'd7),
            1'(ph >= 6 && op == 3'd6),
            1'(ph == 7 && alu),
            1'(ph == 7 && op == 3'd6)};
  endfunction

  int m_ph;
  bit m_h;

  task automatic model_step(input bit r, input bit rn, input logic [2:0] op, input bit sm,
                            input bit st);
    if (r) begin
      m_ph = 0;
      m_h  = 0;
    end else if (m_h) begin
      if (rn) begin
        m_ph = 0;
        m_h  = 0;
      end
    end else if (m_ph == 4 && op == 3'd0) begin
      m_h = 1;
    end else if (!(m_ph == 0 && sm && !st)) begin
      m_ph = (m_ph + 1) % 8;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rows[0] = '{3'd2, 1'b0, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
    rows[1] = '{3'd3, 1'b1, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
    rows[2] = '{3'd4, 1'b0, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
    rows[3] = '{3'd5, 1'b1, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
    rows[4] = '{3'd1, 1'b1, 8'h0F, 8'h0E, 8'h0C, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rows[5] = '{3'd1, 1'b0, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rows[6] = '{3'd6, 1'b0, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h80};
    rows[7] = '{3'd7, 1'b1, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00};

    opcode  = 3'd0;
    is_zero = 1'b0;
    run     = 1'b0;
    rst     = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
    step_mode = 1'b0;
    step      = 1'b0;
`endif
    #1;
    do_reset();
    check("reset state", dut_v, {3'd0, 9'b1000_0_0000});

    // One full instruction per table row, starting from phase 0.
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < 8; p++) begin
        logic [11:0] exp;
        logic [2:0]  p3;
        opcode  = rows[r].op;
        is_zero = rows[r].z;
        p3      = 3'(p);
        exp     = {p3, rows[r].m_sel[p], rows[r].m_rd[p], rows[r].m_ld_ir[p],
                   rows[r].m_inc_pc[p], rows[r].m_halt[p], rows[r].m_ld_pc[p],
                   rows[r].m_data_e[p], rows[r].m_ld_ac[p], rows[r].m_wr[p]};
        #1;
        check($sformatf("table op=%0d z=%0d phase=%0d", rows[r].op, rows[r].z, p), dut_v, exp);
        tick();
      end
    end

    // Reset in the middle of an ADD.
    opcode  = 3'd2;
    is_zero = 1'b0;
    repeat (5) tick();
    check("ADD reached phase 5", dut_v, {3'd5, 9'b0100_0_0000});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset mid-instruction", dut_v, {3'd0, 9'b1000_0_0000});

    // HLT, with run pulses that must be ignored while not halted.
    opcode = 3'd0;
    tick();
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    check("run ignored while running", dut_v, {3'd3, 9'b1110_0_0000});
    tick();
    check("HLT phase 4", dut_v, {3'd4, 9'b0001_1_0000});
    run = 1'b1;
    tick();
    run = 1'b0;
    check("run at HLT edge ignored", dut_v, {3'd4, 9'b0000_1_0000});
    for (int i = 0; i < 20; i++) begin
      opcode = 3'($urandom_range(0, 7));
      tick();
      check($sformatf("halted hold %0d", i), dut_v, {3'd4, 9'b0000_1_0000});
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    check("resume to phase 0", dut_v, {3'd0, 9'b1000_0_0000});

`ifdef CTRL_SINGLE_STEP_EN
    step_mode = 1'b1;
    opcode    = 3'd2;
    is_zero   = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("step hold %0d", i), dut_v, {3'd0, 9'b1000_0_0000});
      tick();
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step to phase 1", dut_v, {3'd1, 9'b1100_0_0000});
    for (int p = 2; p < 8; p++) begin
      tick();
      check($sformatf("step instr phase %0d", p), dut_v, model_out(p, 0, 3'd2, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("step rehold %0d", i), dut_v, {3'd0, 9'b1000_0_0000});
    end
    step_mode = 1'b0;
`endif

    // Random stimulus against the reference model.
    do_reset();
    m_ph = 0;
    m_h  = 0;
    for (int i = 0; i < 1500; i++) begin
      if (m_h || m_ph < 3) opcode = 3'($urandom_range(0, 7));
      is_zero = 1'($urandom_range(0, 1));
      run     = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      #1;
      check($sformatf("random cycle %0d", i), dut_v, model_out(m_ph, m_h, opcode, is_zero));
      @(posedge clk);
      model_step(rst, run, opcode, 1'b0, 1'b0);
      #1;
    end
    rst = 1'b0;
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
